conf_int_acc__dot_prod: RTL

Downstream accumulate stage for the configurable integer multiplier. It consumes the multiplier's registered product stream and sums a programmed number of products into a wide accumulator, forming a dot product. The result is presented through a valid/ready handshake. Approximate mode zeroes the low, approximate-domain bits of each product, matching the multiplier's rapx-gated bit split.

---
 rtl/conf_int_acc__dot_prod.sv | 123 ++++++++++++
 1 files changed

// File: rtl/conf_int_acc__dot_prod.sv
// Dot-product accumulate stage behind the configurable integer multiplier.
// Define CONF_INT_ACC_SAT_EN to saturate the accumulator and report sticky overflow on ovf.
//
// state | meaning
// IDLE  | waiting for start; out_data keeps the last result
// ACC   | summing len products, one per in_valid cycle
// HOLD  | result presented until out_ready
module conf_int_acc__dot_prod #(
   parameter int OP_BITWIDTH        = 16,
   parameter int DATA_PATH_BITWIDTH = 16,
   parameter int ACC_BITWIDTH       = 40,
   parameter int LEN_BITWIDTH       = 8
) (
   input  logic                          clk,
   input  logic                          racc,
   input  logic                          start,
   input  logic [LEN_BITWIDTH-1:0]       len,
   input  logic                          apx_en,
   input  logic                          in_valid,
   input  logic [DATA_PATH_BITWIDTH-1:0] in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_BITWIDTH-1:0]       out_data,
   output logic                          busy,
   output logic                          ovf
);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t                        state;
   state_t                        state_nxt;
   logic [ACC_BITWIDTH-1:0]       acc;
   logic [LEN_BITWIDTH-1:0]       cnt;
   logic                          apx_q;
   logic [DATA_PATH_BITWIDTH-1:0] keep_mask;
   logic [DATA_PATH_BITWIDTH-1:0] masked;

   // Bits kept in approximate mode: only the accurate-domain upper field.
   generate
      if (DATA_PATH_BITWIDTH == OP_BITWIDTH) begin : g_no_apx_field
         assign keep_mask = '1;
      end else begin : g_apx_field
         assign keep_mask = {{OP_BITWIDTH{1'b1}}, {(DATA_PATH_BITWIDTH-OP_BITWIDTH){1'b0}}};
      end
   endgenerate

   assign masked = apx_q ? (in_data & keep_mask) : in_data;

`ifdef CONF_INT_ACC_SAT_EN
   logic                  ovf_q;
   logic [ACC_BITWIDTH:0] sum_full;
   assign sum_full = {1'b0, acc} + {{(ACC_BITWIDTH+1-DATA_PATH_BITWIDTH){1'b0}}, masked};
   assign ovf      = ovf_q;
`else
   logic [ACC_BITWIDTH-1:0] sum_wrap;
   assign sum_wrap = acc + {{(ACC_BITWIDTH-DATA_PATH_BITWIDTH){1'b0}}, masked};
   assign ovf      = 1'b0;
`endif

   assign in_ready  = (state == ACC);
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign out_data  = acc;

   always_ff @(posedge clk) begin
      if (!racc) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = (len == '0) ? HOLD : ACC;
         ACC:  if (in_valid && cnt == LEN_BITWIDTH'(1)) state_nxt = HOLD;
         HOLD: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!racc) begin
         acc   <= '0;
         cnt   <= '0;
         apx_q <= 1'b0;
`ifdef CONF_INT_ACC_SAT_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
`ifdef CONF_INT_ACC_SAT_EN
                  ovf_q <= 1'b0;
`endif
                  if (len != '0) begin
                     cnt   <= len;
                     apx_q <= apx_en;
                  end
               end
            end
            ACC: begin
               if (in_valid) begin
                  cnt <= cnt - LEN_BITWIDTH'(1);
`ifdef CONF_INT_ACC_SAT_EN
                  if (sum_full[ACC_BITWIDTH]) begin
                     acc   <= '1;
                     ovf_q <= 1'b1;
                  end else begin
                     acc <= sum_full[ACC_BITWIDTH-1:0];
                  end
`else
                  acc <= sum_wrap;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
